// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - FWD_* : encodings of the EX operand-mux select
//       00 register-file value read in ID
//       01 EX/MEM ALU result
//       10 MEM/WB write-back data
//       11 WB-hold register (value written back one cycle earlier)
//   - REG_ZERO   : index of the hard-wired zero register (never forwarded)
//   - pipe_tag_t : destination-register tag carried down the shadow pipeline
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;
  localparam logic [1:0] FWD_WBHOLD  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_src_match.sv
// ---------------------------------------------------------------------------
// fwd_src_match
//   Purely combinational priority matcher for one ALU source operand.
//   Compares the source register read in ID against the EX, MEM and WB
//   destination tags and picks the nearest producer.
//
//   Ports:
//     src_i        source register address read by the ID instruction
//     use_i        instruction actually reads this source
//     ex_valid_i   EX tag valid       ex_addr_i   EX tag destination
//     mem_valid_i  MEM tag valid      mem_addr_i  MEM tag destination
//     wb_valid_i   WB tag valid       wb_addr_i   WB tag destination
//     sel_o        operand-mux select to register into EX
//     ex_hit_o     source matches the EX tag (feeds load-use detection)
// ---------------------------------------------------------------------------
module fwd_src_match
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned ZERO_REG = REG_ZERO
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic              use_i,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic [1:0]        sel_o,
  output logic              ex_hit_o
);

  logic qual;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    // The zero register always reads as 0 from the register file, so a
    // "write" to it must never be forwarded.
    qual     = use_i && (src_i != ADDR_W'(ZERO_REG));
    ex_hit_o = qual && ex_valid_i  && (ex_addr_i  == src_i);
    mem_hit  = qual && mem_valid_i && (mem_addr_i == src_i);
    wb_hit   = qual && wb_valid_i  && (wb_addr_i  == src_i);

    // Nearest producer wins. The select is registered into EX, so each
    // producer has advanced one stage by the time the consumer uses it.
    if (ex_hit_o) begin
      sel_o = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_o = FWD_MEMWB;
    end else if (wb_hit) begin
      sel_o = FWD_WBHOLD;
    end else begin
      sel_o = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// ---------------------------------------------------------------------------
// ex_forward_ctrl
//   Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
//   Keeps a shadow pipeline of destination tags (EX, MEM, WB, HOLD) and
//   computes the EX operand-mux selects for the instruction in ID, registering
//   them so they arrive together with that instruction in EX.
//
//   Optional build macro FWD_PERF_EN adds performance counters
//   stall_cnt / fwd_cnt (32-bit, wrapping, cleared by rst_n).
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     hold           global freeze: tags and selects keep their values
//     flush          kill the instruction in ID
//     id_valid       ID holds a real instruction
//     id_rs, id_rt   source registers; id_use_rs / id_use_rt read flags
//     id_wr_en       instruction writes id_wr_addr
//     id_is_load     instruction is a load
//     fwd_sel_a/b    registered EX operand-mux selects
//     stall          combinational load-use stall request
//     stall_cnt      (FWD_PERF_EN) non-held cycles with stall = 1
//     fwd_cnt        (FWD_PERF_EN) count of non-regfile selects registered
//
//   Handshake: there is no valid/ready pair here; the pipeline advances on
//   every edge with hold = 0, and stall tells PC/IF-ID to re-present the
//   same ID instruction on the next cycle while EX receives a bubble.
// ---------------------------------------------------------------------------
module ex_forward_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned ZERO_REG = REG_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic              id_is_load,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  // Shadow tag pipeline
  pipe_tag_t ex_q, mem_q, wb_q, hold_q;
  pipe_tag_t ex_d;

  logic [1:0] fwd_sel_a_q, fwd_sel_a_d;
  logic [1:0] fwd_sel_b_q, fwd_sel_b_d;

  logic [1:0] sel_a_raw, sel_b_raw;
  logic       ex_hit_a, ex_hit_b;
  logic       accept;

  // Per-operand matchers against the tags as they stand this cycle.
  fwd_src_match #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_match_rs (
    .src_i       (id_rs),
    .use_i       (id_use_rs),
    .ex_valid_i  (ex_q.valid),
    .ex_addr_i   (ADDR_W'(ex_q.addr)),
    .mem_valid_i (mem_q.valid),
    .mem_addr_i  (ADDR_W'(mem_q.addr)),
    .wb_valid_i  (wb_q.valid),
    .wb_addr_i   (ADDR_W'(wb_q.addr)),
    .sel_o       (sel_a_raw),
    .ex_hit_o    (ex_hit_a)
  );

  fwd_src_match #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_match_rt (
    .src_i       (id_rt),
    .use_i       (id_use_rt),
    .ex_valid_i  (ex_q.valid),
    .ex_addr_i   (ADDR_W'(ex_q.addr)),
    .mem_valid_i (mem_q.valid),
    .mem_addr_i  (ADDR_W'(mem_q.addr)),
    .wb_valid_i  (wb_q.valid),
    .wb_addr_i   (ADDR_W'(wb_q.addr)),
    .sel_o       (sel_b_raw),
    .ex_hit_o    (ex_hit_b)
  );

  // Load-use: the load's data only exists after MEM, so a consumer directly
  // behind it must wait one cycle. Flush overrides: the consumer is dead.
  always_comb begin
    stall = id_valid && !flush && ex_q.valid && ex_q.is_load &&
            (ex_hit_a || ex_hit_b);
  end

  always_comb begin
    accept      = id_valid && !flush && !stall;
    ex_d        = TAG_BUBBLE;
    fwd_sel_a_d = FWD_REGFILE;
    fwd_sel_b_d = FWD_REGFILE;
    if (accept) begin
      fwd_sel_a_d = sel_a_raw;
      fwd_sel_b_d = sel_b_raw;
      if (id_wr_en) begin
        ex_d.valid   = 1'b1;
        ex_d.addr    = REG_ADDR_W'(id_wr_addr);
        ex_d.is_load = id_is_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= TAG_BUBBLE;
      mem_q       <= TAG_BUBBLE;
      wb_q        <= TAG_BUBBLE;
      hold_q      <= TAG_BUBBLE;
      fwd_sel_a_q <= FWD_REGFILE;
      fwd_sel_b_q <= FWD_REGFILE;
    end else if (!hold) begin
      hold_q      <= wb_q;
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
    end
  end

  assign fwd_sel_a = fwd_sel_a_q;
  assign fwd_sel_b = fwd_sel_b_q;

  // HOLD mirrors the datapath's WB-hold register; it is never matched in ID
  // because the register file already returns that value. The load flag is
  // only meaningful in EX.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{hold_q, mem_q.is_load, wb_q.is_load};

`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]  fwd_inc;

  always_comb begin
    fwd_inc     = {1'b0, (fwd_sel_a_d != FWD_REGFILE)} +
                  {1'b0, (fwd_sel_b_d != FWD_REGFILE)};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    fwd_cnt_d   = fwd_cnt_q + {30'd0, fwd_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!hold) begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
